// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider path: ratio meter FSM states,
// default sizing and the maximum-period helper.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  localparam int RATIO_WIDTH_DEF = 8;
  localparam int LOCK_COUNT_DEF  = 4;

  // Longest period a counter of the given width can represent.
  function automatic int max_period(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop sampler for a synchronously generated divided clock; flags the
// cycle in which the sampled level first goes high.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s0;
  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= din;
      s1 <= s0;
    end
  end

  assign level = s0;
  assign rise  = s0 & ~s1;

endmodule

// File: rtl/clk_ratio_meter.sv
// Counts reference-clock cycles per divided-clock period, reports period and
// high time, flags lock after repeated identical periods and a stall timeout.
module clk_ratio_meter
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = RATIO_WIDTH_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_meas_en,
  input  logic                   i_div_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic [RATIO_WIDTH-1:0] o_high_cnt,
  output logic                   o_valid,
  output logic                   o_locked,
  output logic                   o_timeout
);

  localparam logic [RATIO_WIDTH-1:0] MAX_PER = RATIO_WIDTH'(max_period(RATIO_WIDTH));

  meter_state_e           state;
  meter_state_e           state_next;
  logic                   level;
  logic                   rise;
  logic [RATIO_WIDTH-1:0] per_cnt;
  logic [RATIO_WIDTH-1:0] hi_cnt;
  logic [3:0]             match_cnt;
  logic [3:0]             match_next;
  logic                   seen;
  logic                   clear_cnt;
  logic                   start_cnt;
  logic                   inc_cnt;
  logic                   capture;
  logic                   timeout;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  edge_detect u_edge (
    .clk   (i_ref_clk),
    .rst   (i_rst),
    .din   (i_div_clk),
    .level (level),
    .rise  (rise)
  );

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_meas_en) state_next = ARM;
      ARM:     if (!i_meas_en) state_next = IDLE;
               else if (rise) state_next = MEASURE;
      MEASURE: if (!i_meas_en) state_next = IDLE;
               else if (!rise && per_cnt == MAX_PER) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  // A rise coinciding with a full counter is a capture, never a timeout.
  always_comb begin
    capture   = 1'b0;
    timeout   = 1'b0;
    start_cnt = 1'b0;
    inc_cnt   = 1'b0;
    clear_cnt = 1'b0;
    if (!i_meas_en || state == IDLE) begin
      clear_cnt = 1'b1;
    end else if (state == ARM) begin
      start_cnt = rise;
    end else if (state == MEASURE) begin
      if (rise) begin
        capture   = 1'b1;
        start_cnt = 1'b1;
      end else if (per_cnt == MAX_PER) begin
        timeout   = 1'b1;
        clear_cnt = 1'b1;
      end else begin
        inc_cnt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst || clear_cnt) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (start_cnt) begin
      per_cnt <= RATIO_WIDTH'(1);
      hi_cnt  <= RATIO_WIDTH'(1);
    end else if (inc_cnt) begin
      per_cnt <= per_cnt + RATIO_WIDTH'(1);
      hi_cnt  <= hi_cnt + RATIO_WIDTH'(level);
    end
  end

  assign match_next = (seen && per_cnt == o_ratio) ? sat_inc(match_cnt) : 4'd1;

  // Outputs and lock tracking; seen is cleared whenever the meter re-arms.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_timeout  <= 1'b0;
      match_cnt  <= '0;
      seen       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_meas_en) begin
        o_locked  <= 1'b0;
        match_cnt <= '0;
        seen      <= 1'b0;
      end else if (capture) begin
        o_ratio    <= per_cnt;
        o_high_cnt <= hi_cnt;
        o_valid    <= 1'b1;
        o_timeout  <= 1'b0;
        o_locked   <= int'(match_next) >= LOCK_COUNT;
        match_cnt  <= match_next;
        seen       <= 1'b1;
      end else if (timeout) begin
        o_ratio    <= '0;
        o_high_cnt <= '0;
        o_locked   <= 1'b0;
        o_timeout  <= 1'b1;
        match_cnt  <= '0;
        seen       <= 1'b0;
      end else if (state == IDLE) begin
        match_cnt <= '0;
        seen      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: driven periods feed a period-level
// reference model whose predicted captures are matched against o_valid.
module tb_clk_ratio_meter;

  localparam int LOCK = 4;
  localparam int MAXP = 255;

  typedef struct {
    int ratio;
    int high;
    bit locked;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       meas_en;
  logic       div_clk;
  logic [7:0] ratio;
  logic [7:0] high_cnt;
  logic       valid;
  logic       locked;
  logic       timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state, expressed in whole periods.
  bit m_en, m_armed, m_seen;
  int m_pend_len, m_pend_hi, m_last_ratio, m_match;

  clk_ratio_meter #(.RATIO_WIDTH(8), .LOCK_COUNT(LOCK)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_meas_en  (meas_en),
    .i_div_clk  (div_clk),
    .o_ratio    (ratio),
    .o_high_cnt (high_cnt),
    .o_valid    (valid),
    .o_locked   (locked),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // A new rising edge closes the pending period and predicts its capture.
  task automatic model_rise(input int len, input int hi);
    exp_t e;
    if (m_en) begin
      if (m_armed) begin
        if (m_seen && m_pend_len == m_last_ratio) m_match = (m_match < 15) ? m_match + 1 : 15;
        else m_match = 1;
        e.ratio  = m_pend_len;
        e.high   = m_pend_hi;
        e.locked = (m_match >= LOCK);
        exp_q.push_back(e);
        m_last_ratio = m_pend_len;
        m_seen = 1'b1;
      end
      m_armed    = 1'b1;
      m_pend_len = len;
      m_pend_hi  = hi;
    end
  endtask

  task automatic drive_bit(input logic d);
    div_clk = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int hi, input int lo);
    model_rise(hi + lo, hi);
    repeat (hi) drive_bit(1'b1);
    repeat (lo) drive_bit(1'b0);
  endtask

  task automatic hold_low(input int n);
    if (m_en && m_armed) begin
      m_pend_len += n;
      if (m_pend_len > MAXP) begin
        m_armed = 1'b0;
        m_seen = 1'b0;
        m_last_ratio = 0;
      end
    end
    repeat (n) drive_bit(1'b0);
  endtask

  task automatic set_en(input logic v);
    meas_en = v;
    m_en = v;
    if (!v) begin
      m_armed = 1'b0;
      m_seen = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_bit(1'b0);
    rst = 1'b0;
    m_armed = 1'b0;
    m_seen = 1'b0;
    m_last_ratio = 0;
    m_match = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got ratio %0d with no capture expected", ratio);
      end else begin
        e = exp_q.pop_front();
        chk("ratio", int'(ratio), e.ratio);
        chk("high_cnt", int'(high_cnt), e.high);
        chk("locked", int'(locked), int'(e.locked));
        chk("timeout_on_capture", int'(timeout), 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    meas_en = 1'b0;
    div_clk = 1'b0;
    m_en = 1'b0;
    m_armed = 1'b0;
    m_seen = 1'b0;
    m_pend_len = 0;
    m_pend_hi = 0;
    m_last_ratio = 0;
    m_match = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ratio", int'(ratio), 0);
    chk("reset_high", int'(high_cnt), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_timeout", int'(timeout), 0);

    set_en(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);

    repeat (6) drive_period(2, 2);
    repeat (6) drive_period(3, 4);
    repeat (6) drive_period(2, 3);

    hold_low(260);
    @(negedge clk);
    chk("timeout_flag", int'(timeout), 1);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_ratio", int'(ratio), 0);
    chk("timeout_high", int'(high_cnt), 0);
    repeat (4) drive_period(2, 2);

    // Reset while locked, during the low phase of a period.
    repeat (5) drive_period(2, 2);
    model_rise(5, 2);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    do_reset();
    @(negedge clk);
    chk("midrst_ratio", int'(ratio), 0);
    chk("midrst_high", int'(high_cnt), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_valid", int'(valid), 0);
    drive_bit(1'b0);
    repeat (5) drive_period(2, 2);

    // Enable drop while locked; periods keep running but nothing is captured.
    set_en(1'b0);
    repeat (2) drive_period(2, 2);
    @(negedge clk);
    chk("disabled_locked", int'(locked), 0);
    chk("disabled_ratio_held", int'(ratio), m_last_ratio);
    set_en(1'b1);
    repeat (5) drive_period(3, 3);

    for (int n = 2; n <= 9; n++) repeat (5) drive_period(n / 2, n - n / 2);

    for (int s = 0; s < 25; s++) begin
      int n, h, r;
      n = int'($urandom_range(30, 2));
      h = int'($urandom_range(n - 1, 1));
      r = int'($urandom_range(6, 1));
      repeat (r) drive_period(h, n - h);
    end

    repeat (3) drive_period(100, 155);
    drive_period(2, 2);

    repeat (6) drive_bit(1'b0);
    @(negedge clk);
    chk("all_captures_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
